// File: rtl/mc_ctrl_pkg.sv
// Shared types and field encodings for the multi-cycle MIPS main controller.
// State encodings are fixed because the debug port exposes them directly.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // An instruction retires on the edge that leaves one of its final states.
    function automatic logic retires(input state_t s, input logic ready);
        case (s)
            S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retires = 1'b1;
            S_MEM_WR:                                      retires = ready;
            default:                                       retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode of the registered state, gated by
// mem_ready in the memory states and by opcode in DECODE.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_R    = 6'd0,
    parameter logic [5:0] OP_LW   = 6'd35,
    parameter logic [5:0] OP_SW   = 6'd43,
    parameter logic [5:0] OP_BEQ  = 6'd4,
    parameter logic [5:0] OP_ADDI = 6'd8,
    parameter logic [5:0] OP_J    = 6'd2
) (
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [5:0] i_opcode,
    input  logic       i_reset,
    output ctrl_t      o_ctrl
);

    logic w_known_op;

    always_comb begin
        w_known_op = (i_opcode == OP_R)   || (i_opcode == OP_LW)  ||
                     (i_opcode == OP_SW)  || (i_opcode == OP_BEQ) ||
                     (i_opcode == OP_ADDI)|| (i_opcode == OP_J);
    end

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMM_SL2;
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.illegal_op = ~w_known_op;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase

        // Reset kills enables combinationally so an in-flight access is dropped at once.
        if (i_reset) begin
            o_ctrl.pc_write      = 1'b0;
            o_ctrl.pc_write_cond = 1'b0;
            o_ctrl.ir_write      = 1'b0;
            o_ctrl.reg_write     = 1'b0;
            o_ctrl.mem_read      = 1'b0;
            o_ctrl.mem_write     = 1'b0;
            o_ctrl.illegal_op    = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state register, next-state logic and
// retired-instruction counter around the control-word decoder.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_R    = 6'd0,
    parameter logic [5:0] OP_LW   = 6'd35,
    parameter logic [5:0] OP_SW   = 6'd43,
    parameter logic [5:0] OP_BEQ  = 6'd4,
    parameter logic [5:0] OP_ADDI = 6'd8,
    parameter logic [5:0] OP_J    = 6'd2,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instr_count;
    ctrl_t            w_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (retires(r_state, mem_ready))
                r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:
                if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) w_next_state = S_MEM_ADDR;
                else if (opcode == OP_R)                w_next_state = S_EXEC;
                else if (opcode == OP_BEQ)              w_next_state = S_BRANCH;
                else if (opcode == OP_ADDI)             w_next_state = S_ADDI_EX;
                else if (opcode == OP_J)                w_next_state = S_JUMP;
                else                                    w_next_state = S_FETCH;
            end
            // Opcode is re-read here; anything other than LW/SW abandons to FETCH.
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      w_next_state = S_MEM_RD;
                else if (opcode == OP_SW) w_next_state = S_MEM_WR;
                else                      w_next_state = S_FETCH;
            end
            S_MEM_RD:
                if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WR:
                if (mem_ready) w_next_state = S_FETCH;
            S_EXEC:    w_next_state = S_R_WB;
            S_ADDI_EX: w_next_state = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    mc_ctrl_decode #(
        .OP_R    (OP_R),
        .OP_LW   (OP_LW),
        .OP_SW   (OP_SW),
        .OP_BEQ  (OP_BEQ),
        .OP_ADDI (OP_ADDI),
        .OP_J    (OP_J)
    ) u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_opcode    (opcode),
        .i_reset     (reset),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_write     = w_ctrl.reg_write;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state         = r_state;
    assign instr_count   = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
    logic        i_or_d, mem_to_reg, reg_dst, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OP_R(6'd0), .OP_LW(6'd35), .OP_SW(6'd43),
        .OP_BEQ(6'd4), .OP_ADDI(6'd8), .OP_J(6'd2), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] en;
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            en = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write};
            checks++;
            if (en !== 6'b0 || illegal_op !== 1'b0) begin
                errors++; $display("FAIL reset_enables: got %b/%b want 000000/0", en, illegal_op);
            end
            checks++;
            if (alu_src_b !== 2'b01 || i_or_d !== 1'b0 || alu_src_a !== 1'b0) begin
                errors++; $display("FAIL reset_selects: got srcb=%b iord=%b srca=%b want 01/0/0", alu_src_b, i_or_d, alu_src_a);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd0) begin
            errors++; $display("FAIL reset_release: got state=%0d cnt=%0d want 0/0", state, instr_count);
        end
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || mem_read !== 1'b1) begin
            errors++; $display("FAIL first_fetch: got ir=%b pc=%b rd=%b want 1/1/1", ir_write, pc_write, mem_read);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'd35; mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (state !== exp_st[c]) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", c, state, exp_st[c]);
            end
            if (c == 1) begin
                checks++;
                if (alu_src_b !== 2'b11 || alu_op !== 2'b00 || alu_src_a !== 1'b0) begin
                    errors++; $display("FAIL lw_decode: got srcb=%b op=%b srca=%b want 11/00/0", alu_src_b, alu_op, alu_src_a);
                end
            end
            if (c == 2) begin
                checks++;
                if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin
                    errors++; $display("FAIL lw_addr: got srca=%b srcb=%b want 1/10", alu_src_a, alu_src_b);
                end
            end
            if (c == 3) begin
                checks++;
                if (mem_read !== 1'b1 || i_or_d !== 1'b1 || ir_write !== 1'b0) begin
                    errors++; $display("FAIL lw_memrd: got rd=%b iord=%b ir=%b want 1/1/0", mem_read, i_or_d, ir_write);
                end
            end
            if (c == 4) begin
                checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || instr_count !== 32'd0) begin
                    errors++; $display("FAIL lw_wb: got rw=%b m2r=%b dst=%b cnt=%0d want 1/1/0/0", reg_write, mem_to_reg, reg_dst, instr_count);
                end
            end
            if (c < 5) tick();
        end
        checks++;
        if (instr_count !== 32'd1) begin
            errors++; $display("FAIL lw_count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_sw_wait();
        opcode = 6'd43; mem_ready = 1'b0;
        tick();
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
            errors++; $display("FAIL fetch_wait: got st=%0d ir=%b pc=%b rd=%b want 0/0/0/1", state, ir_write, pc_write, mem_read);
        end
        mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (state !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1 || instr_count !== 32'd1) begin
                errors++; $display("FAIL sw_wait[%0d]: got st=%0d wr=%b iord=%b cnt=%0d want 5/1/1/1", c, state, mem_write, i_or_d, instr_count);
            end
            tick();
        end
        mem_ready = 1'b1;
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1 || instr_count !== 32'd1) begin
            errors++; $display("FAIL sw_ready: got st=%0d wr=%b cnt=%0d want 5/1/1", state, mem_write, instr_count);
        end
        tick();
        checks++;
        if (state !== 4'd0 || mem_write !== 1'b0 || instr_count !== 32'd2) begin
            errors++; $display("FAIL sw_done: got st=%0d wr=%b cnt=%0d want 0/0/2", state, mem_write, instr_count);
        end
    endtask

    task automatic test_beq_j();
        opcode = 6'd4; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (state !== 4'd8 || pc_write_cond !== 1'b1 || alu_op !== 2'b01 || pc_source !== 2'b01 || pc_write !== 1'b0) begin
            errors++; $display("FAIL beq: got st=%0d pwc=%b op=%b src=%b pw=%b want 8/1/01/01/0", state, pc_write_cond, alu_op, pc_source, pc_write);
        end
        tick();
        opcode = 6'd2;
        tick(); tick();
        checks++;
        if (state !== 4'd9 || pc_write !== 1'b1 || pc_source !== 2'b10 || pc_write_cond !== 1'b0) begin
            errors++; $display("FAIL jump: got st=%0d pw=%b src=%b pwc=%b want 9/1/10/0", state, pc_write, pc_source, pc_write_cond);
        end
        tick();
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd4) begin
            errors++; $display("FAIL beq_j_count: got st=%0d cnt=%0d want 0/4", state, instr_count);
        end
    endtask

    task automatic test_r_addi();
        opcode = 6'd0; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (state !== 4'd6 || alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
            errors++; $display("FAIL r_exec: got st=%0d op=%b srca=%b srcb=%b want 6/10/1/00", state, alu_op, alu_src_a, alu_src_b);
        end
        tick();
        checks++;
        if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            errors++; $display("FAIL r_wb: got st=%0d rw=%b dst=%b m2r=%b want 7/1/1/0", state, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        opcode = 6'd8;
        tick(); tick();
        checks++;
        if (state !== 4'd10 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL addi_ex: got st=%0d srcb=%b srca=%b rw=%b want 10/10/1/0", state, alu_src_b, alu_src_a, reg_write);
        end
        tick();
        checks++;
        if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
            errors++; $display("FAIL addi_wb: got st=%0d rw=%b dst=%b m2r=%b want 11/1/0/0", state, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        checks++;
        if (state !== 4'd0 || instr_count !== 32'd6) begin
            errors++; $display("FAIL r_addi_count: got st=%0d cnt=%0d want 0/6", state, instr_count);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'd63; mem_ready = 1'b1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++; $display("FAIL illegal_in_fetch: got %b want 0", illegal_op);
        end
        tick();
        checks++;
        if (state !== 4'd1 || illegal_op !== 1'b1) begin
            errors++; $display("FAIL illegal_pulse: got st=%0d ill=%b want 1/1", state, illegal_op);
        end
        tick();
        checks++;
        if (state !== 4'd0 || illegal_op !== 1'b0 || instr_count !== 32'd6) begin
            errors++; $display("FAIL illegal_after: got st=%0d ill=%b cnt=%0d want 0/0/6", state, illegal_op, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'd43; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got st=%0d wr=%b want 5/1", state, mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state !== 4'd0 || instr_count !== 32'd0 || i_or_d !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got wr=%b st=%0d cnt=%0d iord=%b want 0/0/0/0", mem_write, state, instr_count, i_or_d);
        end
        mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 4'd1 || instr_count !== 32'd0) begin
            errors++; $display("FAIL mid_restart: got st=%0d cnt=%0d want 1/0", state, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq_j();
        test_r_addi();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
